write_back: RTL and testbench

- Final stage of the 16-bit RISC pipeline; the write side of the register file.
- Accepts completed instructions from execute/memory through a valid/ready handshake and waits for load data when needed.
- Drives the register-file write port (RegWrite, write_reg, write_data) that decode currently ties off.
- Keeps a retired-instruction counter and a sticky load-timeout error.

---
 rtl/risc_pkg.sv | 48 ++++
 rtl/wb_load_timer.sv | 41 ++++
 rtl/write_back.sv | 168 ++++++++++++++++
 tb/tb_write_back.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC pipeline: widths, opcode map,
// write-back FSM states and the destination-register decode helper.
package risc_pkg;

   localparam int DATA_W       = 16;
   localparam int REG_AW       = 3;
   localparam int RET_W        = 16;
   localparam int LOAD_TIMEOUT = 15;
   localparam int TMR_W        = 4;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_ADDI  = 3'b001;
   localparam logic [2:0] OP_LW    = 3'b010;
   localparam logic [2:0] OP_SW    = 3'b011;
   localparam logic [2:0] OP_BEQ   = 3'b100;
   localparam logic [2:0] OP_J     = 3'b101;
   localparam logic [2:0] OP_ANDI  = 3'b110;
   localparam logic [2:0] OP_NOP   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_COMMIT    = 2'b01,
      ST_LOAD_WAIT = 2'b10
   } wb_state_e;

   // Returns {writes, reg}. R0 is hard-wired zero, so a destination of 0
   // is reported as "no write" even for opcodes that normally write.
   function automatic logic [REG_AW:0] dest_of(input logic [2:0]        opcode,
                                               input logic [REG_AW-1:0] rt,
                                               input logic [REG_AW-1:0] rd);
      logic [REG_AW-1:0] r;
      logic              w;
      case (opcode)
         OP_RTYPE: begin w = 1'b1; r = rd; end
         OP_ADDI,
         OP_LW,
         OP_ANDI:  begin w = 1'b1; r = rt; end
         default:  begin w = 1'b0; r = {REG_AW{1'b0}}; end
      endcase
      if (r == {REG_AW{1'b0}}) begin
         w = 1'b0;
      end else begin
         w = w;
      end
      return {w, r};
   endfunction

endpackage

// File: rtl/wb_load_timer.sv
// Loadable down-counter bounding the time write-back waits for load data.
// expire_o flags the decrement that brings the count to zero.
module wb_load_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load has priority, decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A count already at zero also expires so a stray zero load cannot wedge the wait.
   assign expire_o = dec_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/write_back.sv
// Write-back stage: retires instructions, drives the register-file write
// port, counts retirements and flags abandoned loads.
// Optional macro WB_BYPASS_EN adds fwd_valid/fwd_reg/fwd_data outputs that
// mirror the write port so decode can forward in the same cycle.
module write_back
   import risc_pkg::*;
#(
   parameter int P_DATA_W       = DATA_W,
   parameter int P_REG_AW       = REG_AW,
   parameter int P_LOAD_TIMEOUT = LOAD_TIMEOUT,
   parameter int P_RET_W        = RET_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_opcode,
   input  logic [P_REG_AW-1:0] in_rt,
   input  logic [P_REG_AW-1:0] in_rd,
   input  logic [P_DATA_W-1:0] in_result,
   input  logic                mem_rvalid,
   input  logic [P_DATA_W-1:0] mem_rdata,
   output logic                reg_write,
   output logic [P_REG_AW-1:0] write_reg,
   output logic [P_DATA_W-1:0] write_data,
`ifdef WB_BYPASS_EN
   output logic                fwd_valid,
   output logic [P_REG_AW-1:0] fwd_reg,
   output logic [P_DATA_W-1:0] fwd_data,
`endif
   output logic [P_RET_W-1:0]  retired,
   output logic                err_load_timeout
);

   wb_state_e           state_q;
   logic                reg_write_q;
   logic [REG_AW-1:0]   write_reg_q;
   logic [DATA_W-1:0]   write_data_q;
   logic [P_RET_W-1:0]  retired_q;
   logic                err_q;
   logic [REG_AW:0]     ld_dest_q;

   logic                accept_s;
   logic                is_lw_s;
   logic [REG_AW:0]     in_dest_s;
   logic                commit_s;
   logic [REG_AW:0]     commit_dest_s;
   logic [DATA_W-1:0]   commit_data_s;
   logic                tmr_load_s;
   logic                tmr_dec_s;
   logic                tmr_expire_s;

   assign in_ready  = (state_q != ST_LOAD_WAIT);
   assign accept_s  = in_valid && in_ready;
   assign is_lw_s   = (in_opcode == OP_LW);
   assign in_dest_s = dest_of(in_opcode, in_rt, in_rd);

   assign tmr_load_s = accept_s && is_lw_s;
   assign tmr_dec_s  = (state_q == ST_LOAD_WAIT) && !mem_rvalid;

   wb_load_timer #(
      .CNT_W (TMR_W)
   ) u_load_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load_s),
      .load_val_i (TMR_W'(P_LOAD_TIMEOUT)),
      .dec_i      (tmr_dec_s),
      .expire_o   (tmr_expire_s)
   );

   // Select what (if anything) commits at the coming edge: a non-load accept or returning load data.
   always_comb begin
      commit_s      = 1'b0;
      commit_dest_s = {(REG_AW+1){1'b0}};
      commit_data_s = {DATA_W{1'b0}};
      case (state_q)
         ST_IDLE, ST_COMMIT: begin
            if (accept_s && !is_lw_s) begin
               commit_s      = 1'b1;
               commit_dest_s = in_dest_s;
               commit_data_s = in_result;
            end else begin
               commit_s      = 1'b0;
            end
         end
         ST_LOAD_WAIT: begin
            if (mem_rvalid) begin
               commit_s      = 1'b1;
               commit_dest_s = ld_dest_q;
               commit_data_s = mem_rdata;
            end else begin
               commit_s      = 1'b0;
            end
         end
         default: begin
            commit_s = 1'b0;
         end
      endcase
   end

   // Write-back FSM with registered write port, retire counter and sticky timeout error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         reg_write_q  <= 1'b0;
         write_reg_q  <= {REG_AW{1'b0}};
         write_data_q <= {DATA_W{1'b0}};
         retired_q    <= {P_RET_W{1'b0}};
         err_q        <= 1'b0;
         ld_dest_q    <= {(REG_AW+1){1'b0}};
      end else begin
         reg_write_q <= 1'b0;
         if (commit_s) begin
            reg_write_q <= commit_dest_s[REG_AW];
            retired_q   <= retired_q + P_RET_W'(1);
            if (commit_dest_s[REG_AW]) begin
               write_reg_q  <= commit_dest_s[REG_AW-1:0];
               write_data_q <= commit_data_s;
            end else begin
               write_reg_q  <= write_reg_q;
               write_data_q <= write_data_q;
            end
         end else begin
            retired_q <= retired_q;
         end
         case (state_q)
            ST_IDLE, ST_COMMIT: begin
               if (accept_s && is_lw_s) begin
                  ld_dest_q <= in_dest_s;
                  state_q   <= ST_LOAD_WAIT;
               end else if (accept_s) begin
                  state_q   <= ST_COMMIT;
               end else begin
                  state_q   <= ST_IDLE;
               end
            end
            ST_LOAD_WAIT: begin
               if (mem_rvalid) begin
                  state_q <= ST_COMMIT;
               end else if (tmr_expire_s) begin
                  err_q     <= 1'b1;
                  retired_q <= retired_q + P_RET_W'(1);
                  state_q   <= ST_IDLE;
               end else begin
                  state_q <= ST_LOAD_WAIT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign reg_write        = reg_write_q;
   assign write_reg        = write_reg_q;
   assign write_data       = write_data_q;
   assign retired          = retired_q;
   assign err_load_timeout = err_q;

`ifdef WB_BYPASS_EN
   assign fwd_valid = reg_write_q;
   assign fwd_reg   = write_reg_q;
   assign fwd_data  = write_data_q;
`endif

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: stimulus pushes expected register writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_write_back;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opcode;
   logic [2:0]  in_rt;
   logic [2:0]  in_rd;
   logic [15:0] in_result;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        reg_write;
   logic [2:0]  write_reg;
   logic [15:0] write_data;
   logic [15:0] retired;
   logic        err_load_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   logic [18:0] exp_q[$];

   write_back dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_opcode        (in_opcode),
      .in_rt            (in_rt),
      .in_rd            (in_rd),
      .in_result        (in_result),
      .mem_rvalid       (mem_rvalid),
      .mem_rdata        (mem_rdata),
      .reg_write        (reg_write),
      .write_reg        (write_reg),
      .write_data       (write_data),
      .retired          (retired),
      .err_load_timeout (err_load_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every write the DUT shows must match the oldest expected write.
   always @(negedge clk) begin
      logic [18:0] e;
      if (rst_n === 1'b1 && reg_write === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write", write_reg, write_data);
         end else begin
            e = exp_q.pop_front();
            if ({write_reg, write_data} !== e) begin
               n_bad++;
               $display("FAIL write_port: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                        write_reg, write_data, e[18:16], e[15:0]);
            end
         end
      end
   end

   // Offer one instruction for one edge; non-load writes are predicted from the opcode map.
   task automatic send(input logic [2:0] op, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] res);
      logic [2:0] dst;
      logic       wr;
      in_valid  = 1'b1;
      in_opcode = op;
      in_rt     = rt;
      in_rd     = rd;
      in_result = res;
      case (op)
         3'b000:                 begin wr = 1'b1; dst = rd; end
         3'b001, 3'b110:         begin wr = 1'b1; dst = rt; end
         default:                begin wr = 1'b0; dst = 3'd0; end
      endcase
      if (wr && dst != 3'd0) exp_q.push_back({dst, res});
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      in_valid  = 1'b0;
      in_opcode = 3'b111;
   endtask

   initial begin
      int cnt;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_opcode  = 3'b111;
      in_rt      = 3'd0;
      in_rd      = 3'd0;
      in_result  = 16'h0000;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_write_reg", {29'd0, write_reg}, 32'd0);
      chk("rst_write_data", {16'd0, write_data}, 32'd0);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      chk("rst_err", {31'd0, err_load_timeout}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // RTYPE rd=3: write visible in the cycle after accept
      send(3'b000, 3'd1, 3'd3, 16'h1234);
      quiet();
      @(negedge clk);
      chk("rtype_reg_write", {31'd0, reg_write}, 32'd1);
      chk("rtype_retired", {16'd0, retired}, 32'd1);

      // ADDI then ANDI back to back
      send(3'b001, 3'd5, 3'd0, 16'hFFF9);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      send(3'b110, 3'd2, 3'd7, 16'h0007);
      quiet();
      @(negedge clk);
      chk("b2b_second_write", {31'd0, reg_write}, 32'd1);
      chk("b2b_retired", {16'd0, retired}, 32'd3);
      @(negedge clk);
      chk("idle_no_write", {31'd0, reg_write}, 32'd0);

      // rvalid while idle is ignored
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hCAFE;
      @(negedge clk);
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("idle_rvalid_retired", {16'd0, retired}, 32'd3);

      // LW rt=4, data in third wait cycle
      send(3'b010, 3'd4, 3'd0, 16'h0000);
      quiet();
      exp_q.push_back({3'd4, 16'hBEEF});
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk("lw_in_ready_low", {31'd0, in_ready}, 32'd0);
         if (i == 3) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hBEEF;
         end
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("lw_reg_write", {31'd0, reg_write}, 32'd1);
      chk("lw_err", {31'd0, err_load_timeout}, 32'd0);
      chk("lw_retired", {16'd0, retired}, 32'd4);

      // LW rt=7, data arrives on the cycle the counter reaches zero: data wins
      send(3'b010, 3'd7, 3'd0, 16'h0000);
      quiet();
      exp_q.push_back({3'd7, 16'h5A5A});
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 15) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h5A5A;
         end
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("edge_reg_write", {31'd0, reg_write}, 32'd1);
      chk("edge_err", {31'd0, err_load_timeout}, 32'd0);
      chk("edge_retired", {16'd0, retired}, 32'd5);

      // LW rt=6 with no data: abandoned after 15 wait cycles
      send(3'b010, 3'd6, 3'd0, 16'h0000);
      quiet();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) break;
         cnt++;
      end
      chk("timeout_wait_cycles", cnt, 32'd15);
      chk("timeout_err", {31'd0, err_load_timeout}, 32'd1);
      chk("timeout_retired", {16'd0, retired}, 32'd6);
      chk("timeout_no_write", {31'd0, reg_write}, 32'd0);

      // RTYPE rd=0 and SW: retire without writing
      send(3'b000, 3'd2, 3'd0, 16'hAAAA);
      send(3'b011, 3'd1, 3'd2, 16'h5555);
      quiet();
      @(negedge clk);
      chk("nowrite_reg_write", {31'd0, reg_write}, 32'd0);
      chk("nowrite_retired", {16'd0, retired}, 32'd8);

      // Reset during LOAD_WAIT
      send(3'b010, 3'd3, 3'd0, 16'h0000);
      quiet();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_retired", {16'd0, retired}, 32'd0);
      chk("midrst_err", {31'd0, err_load_timeout}, 32'd0);
      chk("midrst_write_reg", {29'd0, write_reg}, 32'd0);
      chk("midrst_write_data", {16'd0, write_data}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("postrst_no_write", {31'd0, reg_write}, 32'd0);
      end
      mem_rvalid = 1'b0;
      chk("postrst_retired", {16'd0, retired}, 32'd0);

      // Retire counter wrap
      for (int i = 0; i < 65535; i++) begin
         send(3'b111, 3'd0, 3'd0, 16'h0000);
      end
      quiet();
      @(negedge clk);
      chk("wrap_all_ones", {16'd0, retired}, 32'h0000FFFF);
      send(3'b111, 3'd0, 3'd0, 16'h0000);
      quiet();
      @(negedge clk);
      chk("wrap_to_zero", {16'd0, retired}, 32'd0);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
